// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the processor dmem port.
// Word-addressed RAM plus a 16-word MMIO window (STATUS, INPUT, EVT FIFO,
// TIMER). Read data is registered with one cycle of latency.
// Optional feature: define DMEM_MMIO_TIMER_EN to build the free-running
// cycle timer at MMIO offset 0x3; without it that offset reads 0.
module dmem_responder #(
  parameter int unsigned RAM_AW    = 12,
  parameter int unsigned FIFO_AW   = 3,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  input  logic [31:0] ctrl_in,
  input  logic        ctrl_in_valid,
  output logic [31:0] evt_data,
  output logic        evt_valid,
  input  logic        evt_ready
);

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;

  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_INPUT  = 4'h1;
  localparam logic [3:0] OFF_EVT    = 4'h2;
  localparam logic [3:0] OFF_TIMER  = 4'h3;

  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

  // Address decode
  logic              is_mmio;
  logic [3:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_wr;
  logic              status_wr;
  logic              evt_push_req;
  logic              input_rd;

  assign is_mmio      = (address_dmem[31:4] == MMIO_BASE[31:4]);
  assign mmio_off     = address_dmem[3:0];
  assign ram_idx      = address_dmem[RAM_AW-1:0];
  assign ram_wr       = wren && !is_mmio;
  assign status_wr    = wren && is_mmio && (mmio_off == OFF_STATUS);
  assign evt_push_req = wren && is_mmio && (mmio_off == OFF_EVT);
  assign input_rd     = !wren && is_mmio && (mmio_off == OFF_INPUT);

  // Storage
  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  // FIFO control state
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_ok;
  logic               pop;
  logic               evt_overflow;

  // Input capture state
  logic [DATA_W-1:0] input_reg;
  logic              input_new;

  // Read path
  logic [DATA_W-1:0] timer_rd;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] mmio_rd;
  logic [DATA_W-1:0] rd_data_p1;

  // Count never exceeds the depth, so its MSB alone marks "full".
  assign fifo_full  = fifo_count[FIFO_AW];
  assign fifo_empty = (fifo_count == '0);
  // Fullness is judged before this edge's pop, so a pop never makes room
  // for a push on the same edge.
  assign push_ok    = evt_push_req && !fifo_full;
  assign pop        = !fifo_empty && evt_ready;

  assign evt_valid  = !fifo_empty;
  assign evt_data   = fifo_mem[rd_ptr];

  // RAM write port; reset blocks a concurrent write
  always_ff @(posedge clock) begin
    if (reset && ram_wr) begin
      ram[ram_idx] <= data;
    end
  end

  // FIFO storage write; only accepted pushes land in memory
  always_ff @(posedge clock) begin
    if (reset && push_ok) begin
      fifo_mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      // A status write and an EVT push cannot share an edge (one address).
      if (status_wr) begin
        evt_overflow <= 1'b0;
      end else if (evt_push_req && fifo_full) begin
        evt_overflow <= 1'b1;
      end
    end
  end

  // Controller input snapshot; a new capture outranks the read-clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      input_reg <= '0;
      input_new <= 1'b0;
    end else if (ctrl_in_valid) begin
      input_reg <= ctrl_in;
      input_new <= 1'b1;
    end else if (input_rd) begin
      input_new <= 1'b0;
    end
  end

`ifdef DMEM_MMIO_TIMER_EN
  logic              timer_wr;
  logic [DATA_W-1:0] timer;

  assign timer_wr = wren && is_mmio && (mmio_off == OFF_TIMER);
  assign timer_rd = timer;

  // Free-running cycle timer; a software load takes precedence over counting
  always_ff @(posedge clock) begin
    if (!reset) begin
      timer <= '0;
    end else if (timer_wr) begin
      timer <= data;
    end else begin
      timer <= timer + 32'd1;
    end
  end
`else
  assign timer_rd = '0;
`endif

  // STATUS word assembled from pre-edge state
  always_comb begin
    status_word       = '0;
    status_word[0]    = fifo_full;
    status_word[1]    = fifo_empty;
    status_word[2]    = evt_overflow;
    status_word[3]    = input_new;
    status_word[11:8] = 4'(fifo_count);
  end

  // MMIO read mux; EVT and unmapped offsets read as zero
  always_comb begin
    mmio_rd = '0;
    case (mmio_off)
      OFF_STATUS: mmio_rd = status_word;
      OFF_INPUT:  mmio_rd = input_reg;
      OFF_TIMER:  mmio_rd = timer_rd;
      default:    mmio_rd = '0;
    endcase
  end

  // Stage p0 -> p1: registered read data, RAM read sees pre-write contents
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_data_p1 <= '0;
    end else if (is_mmio) begin
      rd_data_p1 <= mmio_rd;
    end else begin
      rd_data_p1 <= ram[ram_idx];
    end
  end

  assign q_dmem = rd_data_p1;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined processor's dmem port. Each cycle it samples `address_dmem`, `data` and `wren` and returns registered read data on `q_dmem`. It holds a word-addressed data RAM and a small memory-mapped I/O window: a controller-input snapshot register, an outbound event FIFO with valid/ready drain, and an optional cycle timer. It sits in the wrapper between the processor and the game peripherals (paddle input, score/sound event consumer).

## Interface
Parameters:
- `RAM_AW`, 12: RAM address width; depth is 2^RAM_AW words of 32 bits.
- `FIFO_AW`, 3: event FIFO address width; depth is 2^FIFO_AW entries.
- `MMIO_BASE`, 32'hFFFF_FFF0: MMIO window base; bits [3:0] must be 0.

Ports:
- `clock`  in  1  master clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `address_dmem`  in  32  word address from the processor.
- `data`  in  32  write data.
- `wren`  in  1  write enable.
- `q_dmem`  out  32  registered read data.
- `ctrl_in`  in  32  controller/paddle input word.
- `ctrl_in_valid`  in  1  capture strobe for `ctrl_in`.
- `evt_data`  out  32  FIFO head word.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_ready`  in  1  consumer accepts the head.

## Operation
- **Decode**
  - MMIO when `address_dmem[31:4] == MMIO_BASE[31:4]`; offset is `address_dmem[3:0]`.
  - Otherwise RAM, indexed by `address_dmem[RAM_AW-1:0]`. Upper bits are ignored, so out-of-range addresses alias.
- **RAM**
  - Write on an edge with `wren`=1.
  - Read returns the pre-write contents when a read and write hit the same address in the same cycle.
  - RAM contents are not cleared by reset.
- **MMIO map**
  - 0x0 STATUS (R): bit0 fifo_full, bit1 fifo_empty, bit2 evt_overflow (sticky), bit3 input_new, bits[11:8] fifo count (zero-extended), all other bits 0. Any write clears evt_overflow.
  - 0x1 INPUT (R): last captured `ctrl_in`. A read clears input_new. Writes are ignored.
  - 0x2 EVT (W): pushes `data` into the FIFO. Reads return 0.
  - 0x3 TIMER (R/W): see Configuration.
  - All other offsets read 0 and ignore writes. MMIO writes never reach RAM.
- **FIFO**
  - Push is accepted only if count < depth at that edge. A pop in the same edge does not free a slot for the push.
  - A rejected push sets evt_overflow.
  - Pop occurs when `evt_valid && evt_ready`.
  - Simultaneous accepted push and pop leaves count unchanged.
  - Pointers wrap modulo depth; count is FIFO_AW+1 bits wide.
- **Input capture**
  - On `ctrl_in_valid`=1, latch `ctrl_in` and set input_new.
  - If an INPUT read and a capture occur on the same edge: set wins, and `q_dmem` returns the old value.

## Timing
- Read latency is 1 cycle. Data for the address presented at edge N is on `q_dmem` after edge N and holds until edge N+1. This is stable before the processor's falling-edge capture.
- MMIO reads are registered identically to RAM reads. STATUS and TIMER reflect state *before* edge N's updates.
- `evt_valid` equals !empty. `evt_data` equals the head entry, combinational from FIFO storage and pointers.
- A pushed word appears on `evt_data`/`evt_valid` the cycle after the push edge. It is never visible in the same cycle.
- Reset (`reset`=0 at an edge) forces:
  - `q_dmem`=0, FIFO empty, `evt_valid`=0;
  - evt_overflow=0, input_new=0, INPUT=0, TIMER=0.
- Reset mid-operation discards FIFO contents and any in-flight read. Reset has priority over every concurrent write, push, pop or capture.

## Configuration
- **`DMEM_MMIO_TIMER_EN` defined:**
  - TIMER is a 32-bit counter that increments every non-reset edge and wraps 0xFFFFFFFF→0.
  - A write to offset 0x3 loads `data`; the load wins over the increment, and the counter increments from the loaded value on the next edge.
  - Read returns the pre-edge value.
- **Undefined:** no counter is built. Offset 0x3 reads 0 and ignores writes.

## Test plan
- **RAM write/read:** write 0xDEADBEEF to address 5, then read address 5 → `q_dmem`=0xDEADBEEF one cycle later. Read address 5+2^RAM_AW → same value (aliasing).
- **FIFO fill with overflow:** push 0x1..0x9 to MMIO_BASE+2 with `evt_ready`=0 → STATUS=0x0000_0805 (count 8, full, overflow). `evt_data`=0x1.
- **FIFO drain:** raise `evt_ready` → words 0x1..0x8 in order, `evt_valid` drops after the eighth. Then write STATUS → overflow cleared, STATUS=0x2.
- **Input capture race:** capture 0x55, then on one edge both capture 0xAA and read INPUT → `q_dmem`=0x55, input_new=1. Next read INPUT → 0xAA, input_new=0.
- **Timer (with `DMEM_MMIO_TIMER_EN`):** write 0xFFFFFFFE to TIMER, then read at the next two edges → 0xFFFFFFFE, then 0xFFFFFFFF. Following read → 0x0.
- **Reset mid-traffic:** with 3 FIFO entries and a pending read, assert `reset`=0 for one edge → `q_dmem`=0, `evt_valid`=0, STATUS=0x2. Previously written RAM data is intact.
